mips_multicycle_ctl: RTL and testbench
======================================

# mips_multicycle_ctl

Multi-cycle MIPS control FSM, the initiator side of the 32-bit ALU's 4-bit control-line interface. It sequences fetch, decode, execute, memory and writeback. Each cycle it drives the ALU control code, operand-select and datapath enables, and it consumes the ALU's zero flag to resolve branches. It sits between the instruction register and the datapath, replacing a single-cycle combinational main/ALU control decoder.

## Interface
- No parameters. Opcode, funct and ALU codes are fixed constants in the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16], selects REGIMM variant
- zout  in  1  ALU zero flag; 1 = result zero / condition true
- alu_ctl  out  4  ALU control line
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- pc_src  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target
- pc_en  out  1  PC write enable
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write, ir_write  out  1 each  memory/IR strobes
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file controls; reg_dst 1 = rd
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state encoding, for debug and bench

## Operation
- States:
  - FETCH (0)
  - DECODE (1)
  - MEMADR (2)
  - MEMRD (3)
  - MEMWB (4)
  - MEMWR (5)
  - RTEXEC (6)
  - RTWB (7)
  - BRANCH (8)
  - JUMP (9)
  - IEXEC (10)
  - IWB (11)
  - HALT (12)
- FETCH: mem_read, ir_write, iord=0, alu_src_a=0, alu_src_b=1, alu_ctl=0010, pc_src=0, pc_en=1 → DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctl=0010 (branch target into ALUOut). Next state by opcode:
  - 000000 → RTEXEC
  - 100011 or 101011 → MEMADR
  - 000100, 000101, 000110, 000111, 000001 → BRANCH
  - 000010 → JUMP
  - 001000, 001100, 001101, 001010 → IEXEC
  - otherwise → HALT, and illegal is set.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_ctl=0010. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read, iord=1 → MEMWB.
- MEMWB: reg_write, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write, iord=1 → FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=0. alu_ctl by funct:
  - 100000 → 0010
  - 100010 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 101010 → 0111
  - 100111 → 1100
  - other funct → HALT, illegal set.
  - Supported funct → RTWB.
- RTWB: reg_write, reg_dst=1, mem_to_reg=0 → FETCH.
- IEXEC: alu_src_a=1, alu_src_b=2. alu_ctl: addi 0010, andi 0000, ori 0001, slti 0111 → IWB.
- IWB: reg_write, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, pc_src=1. Opcode → alu_ctl, taken condition:
  - beq → 0110, taken if zout=1
  - bne → 0110, taken if zout=0
  - blez → 1001, taken if zout=1
  - bgtz → 1111, taken if zout=1
  - REGIMM rt=00000 (bltz) → 1011, taken if zout=1
  - REGIMM rt=00001 (bgez) → 1110, taken if zout=1
  - Other rt → HALT, illegal set.
  - pc_en = taken. Next state → FETCH.
- JUMP: pc_src=2, pc_en=1 → FETCH.
- HALT: all enables 0. Stays in HALT until reset.
- Any output not listed for a state is 0, and alu_ctl defaults to 0010.

## Timing
- Reset: when rst_n=0 at a rising edge, state becomes FETCH and illegal is cleared. This applies mid-instruction; no partial write completes after the reset edge.
- Outputs while rst_n=0 are those of FETCH with all write enables (pc_en, ir_write, mem_write, reg_write) forced to 0.
- Outputs are Moore functions of the registered state, plus opcode/funct/rt. The one exception is pc_en in BRANCH, which depends on zout in the same cycle (Mealy).
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - branch 3, taken or not
  - jump 3
- illegal is asserted from the cycle after the offending DECODE/RTEXEC/BRANCH edge and holds until reset.
- zout is sampled only in BRANCH; in every other state it has no effect.

## Structure
- The shared package holds:
  - opcode, funct and REGIMM rt constants
  - ALU control code constants: ADD 0010, SUB 0110, SLT 0111, AND 0000, OR 0001, NOR 1100, BLEZ 1001, BLTZ 1011, BGTZ 1111, BGEZ 1110
  - state encoding constants
- One sub-module, mips_alu_dec: a combinational map from (state, opcode, funct, rt) to alu_ctl plus an unsupported flag. It is reused by any future pipelined control.

## Test plan
- rst_n low 2 cycles mid-MEMRD → state_o=0, mem_read=1, pc_en=0, illegal=0 while rst_n=0; normal FETCH on the first edge after release.
- R-type funct 100010 → states 0,1,6,7,0; alu_ctl=0110 in RTEXEC; reg_write=1 and reg_dst=1 only in RTWB.
- lw then sw → lw walks 0,1,2,3,4 with iord=1 in MEMRD; sw walks 0,1,2,5 with mem_write=1 exactly one cycle.
- beq with zout=1 → pc_en=1, pc_src=1 in BRANCH. bne with zout=1 → pc_en=0. bgez (opcode 000001, rt 00001) → alu_ctl=1110.
- Opcode 111111 → HALT from the next cycle, illegal=1, no enables for 10 cycles; rst_n pulse clears it.
- Branch state with zout toggling → pc_en follows zout in the same cycle; zout toggling in FETCH has no effect.

Source files
------------

// File: rtl/mips_multicycle_ctl_pkg.sv
// Shared constants for the multi-cycle MIPS control: opcodes, functs, REGIMM rt codes,
// ALU control codes and the control FSM state encoding.
package mips_multicycle_ctl_pkg;

   localparam logic [5:0] OpRtype  = 6'b000000;
   localparam logic [5:0] OpRegimm = 6'b000001;
   localparam logic [5:0] OpJ      = 6'b000010;
   localparam logic [5:0] OpBeq    = 6'b000100;
   localparam logic [5:0] OpBne    = 6'b000101;
   localparam logic [5:0] OpBlez   = 6'b000110;
   localparam logic [5:0] OpBgtz   = 6'b000111;
   localparam logic [5:0] OpAddi   = 6'b001000;
   localparam logic [5:0] OpSlti   = 6'b001010;
   localparam logic [5:0] OpAndi   = 6'b001100;
   localparam logic [5:0] OpOri    = 6'b001101;
   localparam logic [5:0] OpLw     = 6'b100011;
   localparam logic [5:0] OpSw     = 6'b101011;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnNor = 6'b100111;
   localparam logic [5:0] FnSlt = 6'b101010;

   localparam logic [4:0] RtBltz = 5'b00000;
   localparam logic [4:0] RtBgez = 5'b00001;

   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluSub  = 4'b0110;
   localparam logic [3:0] AluSlt  = 4'b0111;
   localparam logic [3:0] AluAnd  = 4'b0000;
   localparam logic [3:0] AluOr   = 4'b0001;
   localparam logic [3:0] AluNor  = 4'b1100;
   localparam logic [3:0] AluBlez = 4'b1001;
   localparam logic [3:0] AluBltz = 4'b1011;
   localparam logic [3:0] AluBgtz = 4'b1111;
   localparam logic [3:0] AluBgez = 4'b1110;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StRtExec = 4'd6,
      StRtWb   = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StIExec  = 4'd10,
      StIWb    = 4'd11,
      StHalt   = 4'd12
   } state_e;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational ALU control decode from (state, opcode, funct, rt); flags encodings the
// control cannot execute so the FSM can halt.
module mips_alu_dec
   import mips_multicycle_ctl_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output logic [3:0] alu_ctl,
   output logic       unsupported
);

   state_e st;
   assign st = state_e'(state);

   always_comb begin
      alu_ctl     = AluAdd;
      unsupported = 1'b0;
      case (st)
         StDecode: begin
            case (opcode)
               OpRtype, OpLw, OpSw, OpBeq, OpBne, OpBlez, OpBgtz, OpRegimm, OpJ,
               OpAddi, OpAndi, OpOri, OpSlti: unsupported = 1'b0;
               default: unsupported = 1'b1;
            endcase
         end
         StRtExec: begin
            case (funct)
               FnAdd:   alu_ctl = AluAdd;
               FnSub:   alu_ctl = AluSub;
               FnAnd:   alu_ctl = AluAnd;
               FnOr:    alu_ctl = AluOr;
               FnSlt:   alu_ctl = AluSlt;
               FnNor:   alu_ctl = AluNor;
               default: unsupported = 1'b1;
            endcase
         end
         StIExec: begin
            case (opcode)
               OpAndi:  alu_ctl = AluAnd;
               OpOri:   alu_ctl = AluOr;
               OpSlti:  alu_ctl = AluSlt;
               default: alu_ctl = AluAdd;
            endcase
         end
         StBranch: begin
            case (opcode)
               OpBeq, OpBne: alu_ctl = AluSub;
               OpBlez:       alu_ctl = AluBlez;
               OpBgtz:       alu_ctl = AluBgtz;
               OpRegimm: begin
                  case (rt)
                     RtBltz:  alu_ctl = AluBltz;
                     RtBgez:  alu_ctl = AluBgez;
                     default: unsupported = 1'b1;
                  endcase
               end
               default: alu_ctl = AluAdd;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives
// the ALU control line, operand selects and datapath enables.
module mips_multicycle_ctl
   import mips_multicycle_ctl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   input  logic       zout,
   output logic [3:0] alu_ctl,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_e state_q, state_d;
   state_e cur;
   logic   illegal_q;
   logic   unsupported;
   logic   taken;

   // While reset is held the outputs look like FETCH, independent of the registered state.
   assign cur     = rst_n ? state_q : StFetch;
   assign state_o = cur;
   assign illegal = illegal_q & rst_n;

   mips_alu_dec u_alu_dec (
      .state       (cur),
      .opcode      (opcode),
      .funct       (funct),
      .rt          (rt),
      .alu_ctl     (alu_ctl),
      .unsupported (unsupported)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | unsupported;
      end
   end

   always_comb begin
      taken = (opcode == OpBne) ? ~zout : zout;
   end

   always_comb begin
      state_d    = state_q;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_src     = 2'd0;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (cur)
         StFetch: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'd1;
            pc_en     = 1'b1;
            state_d   = StDecode;
         end
         StDecode: begin
            alu_src_b = 2'd3;
            case (opcode)
               OpRtype:                                state_d = StRtExec;
               OpLw, OpSw:                             state_d = StMemAdr;
               OpBeq, OpBne, OpBlez, OpBgtz, OpRegimm: state_d = StBranch;
               OpJ:                                    state_d = StJump;
               OpAddi, OpAndi, OpOri, OpSlti:          state_d = StIExec;
               default:                                state_d = StHalt;
            endcase
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            state_d   = StFetch;
         end
         StRtExec: begin
            alu_src_a = 1'b1;
            state_d   = unsupported ? StHalt : StRtWb;
         end
         StRtWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            pc_src    = 2'd1;
            // zout is only meaningful here; pc_en follows it combinationally.
            pc_en     = taken & ~unsupported;
            state_d   = unsupported ? StHalt : StFetch;
         end
         StJump: begin
            pc_src  = 2'd2;
            pc_en   = 1'b1;
            state_d = StFetch;
         end
         StIExec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = StIWb;
         end
         StIWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
      if (!rst_n) begin
         pc_en     = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctl.sv
// Bench for mips_multicycle_ctl: random instruction stream checked against a per-instruction
// state-path and per-state output model, plus directed reset, halt and zout cases.
module tb_mips_multicycle_ctl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic [4:0] rt;
   logic       zout;
   logic [3:0] alu_ctl, state_o;
   logic       alu_src_a, pc_en, iord, mem_read, mem_write, ir_write;
   logic       reg_write, reg_dst, mem_to_reg, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [16:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   mips_multicycle_ctl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .rt         (rt),
      .zout       (zout),
      .alu_ctl    (alu_ctl),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   assign outs = {alu_ctl, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_read, mem_write,
                  ir_write, reg_write, reg_dst, mem_to_reg};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit legal_fn(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   endfunction

   // Expected control outputs for a state number, straight from the per-state output table.
   function automatic logic [16:0] model_outs(input int st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic [4:0] r,
                                              input logic z, input logic rn);
      logic [3:0] ac;
      logic       sa, pe, io, mr, mw, iw, rw, rd, m2r;
      logic [1:0] sb, ps;
      ac = 4'b0010; sa = 0; sb = 0; ps = 0; pe = 0; io = 0;
      mr = 0; mw = 0; iw = 0; rw = 0; rd = 0; m2r = 0;
      case (st)
         0: begin mr = 1; iw = 1; sb = 1; pe = 1; end
         1: sb = 3;
         2: begin sa = 1; sb = 2; end
         3: begin mr = 1; io = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mw = 1; io = 1; end
         6: begin
            sa = 1;
            case (fn)
               6'b100010: ac = 4'b0110;
               6'b100100: ac = 4'b0000;
               6'b100101: ac = 4'b0001;
               6'b101010: ac = 4'b0111;
               6'b100111: ac = 4'b1100;
               default:   ac = 4'b0010;
            endcase
         end
         7: begin rw = 1; rd = 1; end
         8: begin
            sa = 1; ps = 1;
            case (op)
               6'b000100: begin ac = 4'b0110; pe = z;  end
               6'b000101: begin ac = 4'b0110; pe = !z; end
               6'b000110: begin ac = 4'b1001; pe = z;  end
               6'b000111: begin ac = 4'b1111; pe = z;  end
               6'b000001: begin
                  if (r == 5'd0) begin ac = 4'b1011; pe = z; end
                  else if (r == 5'd1) begin ac = 4'b1110; pe = z; end
               end
               default: ;
            endcase
         end
         9: begin ps = 2; pe = 1; end
         10: begin
            sa = 1; sb = 2;
            if (op == 6'b001100) ac = 4'b0000;
            else if (op == 6'b001101) ac = 4'b0001;
            else if (op == 6'b001010) ac = 4'b0111;
         end
         11: rw = 1;
         default: ;
      endcase
      if (!rn) begin pe = 0; iw = 0; mw = 0; rw = 0; end
      return {ac, sa, sb, ps, pe, io, mr, mw, iw, rw, rd, m2r};
   endfunction

   // Sequence of states an instruction walks through, by instruction class.
   task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                       output int len, output int s[6]);
      s = '{0, 1, 0, 0, 0, 0};
      if (op == 6'b000000) begin s[2] = 6; s[3] = legal_fn(fn) ? 7 : 12; len = 4; end
      else if (op == 6'b100011) begin s[2] = 2; s[3] = 3; s[4] = 4; len = 5; end
      else if (op == 6'b101011) begin s[2] = 2; s[3] = 5; len = 4; end
      else if (op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111}) begin
         s[2] = 8; len = 3;
      end else if (op == 6'b000001) begin
         s[2] = 8;
         if (r > 5'd1) begin s[3] = 12; len = 4; end else len = 3;
      end else if (op == 6'b000010) begin s[2] = 9; len = 3; end
      else if (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001010}) begin
         s[2] = 10; s[3] = 11; len = 4;
      end else begin s[2] = 12; len = 3; end
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_state", state_o, 0);
      check("rst_outs", outs, model_outs(0, opcode, funct, rt, zout, 1'b0));
      check("rst_illegal", illegal, 0);
      rst_n = 1'b1;
   endtask

   // Entered and left at 1 time unit after a rising edge with the DUT in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
      int len;
      int s[6];
      plan(op, fn, r, len, s);
      opcode = op; funct = fn; rt = r;
      for (int k = 0; k < len; k++) begin
         zout = 1'($urandom);
         #1;
         check("state", state_o, s[k]);
         check("outs", outs, model_outs(s[k], op, fn, r, zout, 1'b1));
         check("illegal", illegal, (s[k] == 12) ? 1 : 0);
         @(posedge clk); #1;
      end
      if (s[len-1] == 12) begin
         for (int c = 0; c < 10; c++) begin
            zout = 1'($urandom);
            #1;
            check("halt_state", state_o, 12);
            check("halt_outs", outs, model_outs(12, op, fn, r, zout, 1'b1));
            check("halt_illegal", illegal, 1);
            @(posedge clk); #1;
         end
         reset_pulse();
      end
   endtask

   logic [5:0] itype_ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
   logic [5:0] br_ops    [4] = '{6'b000100, 6'b000101, 6'b000110, 6'b000111};
   logic [5:0] fn_ops    [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                  6'b100111};

   initial begin
      logic [5:0] op, fn;
      logic [4:0] r;
      rst_n = 1'b0; opcode = '0; funct = '0; rt = '0; zout = 1'b0;
      @(posedge clk); #1;
      reset_pulse();

      // Directed instructions.
      run_instr(6'b000000, 6'b100010, 5'd0);
      run_instr(6'b100011, 6'd0, 5'd0);
      run_instr(6'b101011, 6'd0, 5'd0);
      run_instr(6'b000001, 6'd0, 5'd1);
      run_instr(6'b111111, 6'd0, 5'd0);

      // Reset held two cycles in the middle of a load's MEMRD.
      opcode = 6'b100011;
      #1; check("lw_fetch", state_o, 0);
      @(posedge clk); #1; check("lw_decode", state_o, 1);
      @(posedge clk); #1; check("lw_memadr", state_o, 2);
      @(posedge clk); #1; check("lw_memrd", state_o, 3); check("lw_iord", iord, 1);
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("mid_rst_state", state_o, 0);
         check("mid_rst_mem_read", mem_read, 1);
         check("mid_rst_pc_en", pc_en, 0);
         check("mid_rst_illegal", illegal, 0);
         check("mid_rst_writes", {reg_write, mem_write, ir_write}, 0);
         if (c < 2) begin @(posedge clk); #1; end
      end
      rst_n = 1'b1;
      #1; check("post_rst_state", state_o, 0); check("post_rst_pc_en", pc_en, 1);
      @(posedge clk); #1; check("post_rst_decode", state_o, 1);
      reset_pulse();

      // zout toggling: ignored in FETCH, followed combinationally by pc_en in BRANCH.
      for (int b = 0; b < 2; b++) begin
         opcode = (b == 0) ? 6'b000100 : 6'b000101;
         zout = 1'b0; #1; check("fetch_z0_pc_en", pc_en, 1);
         zout = 1'b1; #1; check("fetch_z1_outs", outs, model_outs(0, opcode, 0, 0, 0, 1));
         @(posedge clk); #1;
         @(posedge clk); #1; check("br_state", state_o, 8);
         check("br_pc_src", pc_src, 1);
         zout = 1'b1; #1; check("br_z1_pc_en", pc_en, (b == 0) ? 1 : 0);
         zout = 1'b0; #1; check("br_z0_pc_en", pc_en, (b == 0) ? 0 : 1);
         zout = 1'b1; #1; check("br_z1b_pc_en", pc_en, (b == 0) ? 1 : 0);
         @(posedge clk); #1; check("br_back_fetch", state_o, 0);
      end

      // Random instruction stream.
      for (int i = 0; i < 300; i++) begin
         fn = 6'($urandom);
         r  = 5'($urandom);
         case ($urandom_range(0, 9))
            0, 1: begin op = 6'b000000; fn = fn_ops[$urandom_range(0, 5)]; end
            2: op = 6'b000000;
            3: op = 6'b100011;
            4: op = 6'b101011;
            5: op = br_ops[$urandom_range(0, 3)];
            6: begin op = 6'b000001; r = 5'($urandom_range(0, 3)); end
            7: op = 6'b000010;
            8: op = itype_ops[$urandom_range(0, 3)];
            default: op = 6'($urandom);
         endcase
         run_instr(op, fn, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
